rv_decode_stage: RTL and testbench
==================================

// Module: rv_decode_stage
// PURPOSE
//  Registered, parametrised RV32I/RV64I opcode-decode pipeline stage with valid/ready on both sides.
//  Classifies every opcode class into a one-hot vector, including an illegal class.
//  Extracts register fields and a sign-extended immediate.
//  Optional skid buffer; counts retired illegal instructions. Sits between fetch and register-read.
// PARAMETERS
//  XLEN   32  immediate/datapath width; legal values 32 or 64
//  SKID   1   1: 1-entry skid buffer, in_ready registered; 0: no buffer, in_ready combinational
//  CNT_W  16  width of saturating illegal-instruction counter
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous, active-low reset
//  flush        in   1       sync; discard all held instructions
//  in_valid     in   1       instruction word valid
//  in_ready     out  1       stage can accept
//  in_inst      in   32      instruction word
//  out_valid    out  1       decoded record valid
//  out_ready    in   1       consumer accepts
//  out_cls      out  10      one-hot class: [0]r_type [1]i_type [2]load [3]store [4]branch
//                            [5]jal [6]jalr [7]auipc [8]lui [9]illegal
//  out_rd       out  5       inst[11:7]
//  out_rs1      out  5       inst[19:15]
//  out_rs2      out  5       inst[24:20]
//  out_funct3   out  3       inst[14:12]
//  out_funct7   out  7       inst[31:25]
//  out_imm      out  XLEN    sign-extended immediate
//  illegal_cnt  out  CNT_W   count of illegal instructions handed off
// BEHAVIOUR
//  - Reset (rst=0, async): out_valid=0, skid empty, out_cls=0, all field outputs=0, illegal_cnt=0.
//    in_ready=0 while rst=0; in_ready=1 on the first clk after release.
//  - Opcode map (inst[6:0]):
//    0110011 r, 0010011 i, 0000011 load, 0100011 store, 1100011 branch, 1101111 jal,
//    1100111 jalr, 0010111 auipc, 0110111 lui.
//    Anything else is illegal, including inst[1:0]!=2'b11 and jalr with funct3!=000.
//  - Exactly one out_cls bit is set whenever out_valid=1.
//  - Immediates, sign-extended from inst[31] to XLEN:
//    I (i_type/load/jalr) = inst[31:20]
//    S = {inst[31:25],inst[11:7]}
//    B = {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}
//    U = {inst[31:12],12'b0}
//    J = {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}
//    r_type and illegal produce imm=0.
//  - Latency: an input accepted at edge N is presented at out_* after edge N; fixed 1 cycle.
//  - Handshake: transfer on valid&&ready at each side. out_* stays stable while out_valid && !out_ready.
//    Order is preserved; there is no drop and no duplication.
//  - SKID=0: in_ready = !out_valid || out_ready.
//  - SKID=1: in_ready = !skid_full (registered).
//    An input accepted while out_valid && !out_ready goes to the skid buffer.
//    The skid entry moves to the output register on the next output transfer.
//    Output register plus skid hold at most 2 records.
//  - Simultaneous input and output transfer: the output register reloads with the skid entry if
//    present, else with the incoming record; the incoming record goes to skid if skid was occupied.
//  - flush=1 at an edge clears out_valid and skid and overrides any same-cycle input transfer.
//    illegal_cnt is unaffected. in_ready=1 on the next cycle.
//  - illegal_cnt increments by 1 on each output transfer with out_cls[9]=1.
//    It saturates at 2^CNT_W-1 and never wraps.
//  - Async reset mid-transfer drops all held records immediately.
// TESTING
//  1. 0x002081B3 (add x3,x1,x2), out_ready=1 -> 1 cycle later out_cls=10'h001, rd=3, rs1=1, rs2=2, imm=0.
//  2. 0xFFF00093 (addi x1,x0,-1) -> out_cls=10'h002, imm=32'hFFFFFFFF (XLEN=64: 64'hFFFF_FFFF_FFFF_FFFF).
//  3. 0x0020A423 (sw x2,8(x1)) -> out_cls=10'h008, imm=8.
//     0xFE000EE3 (beq -4) -> out_cls=10'h010, imm=-4.
//  4. SKID=1, out_ready=0, stream A,B,C -> A,B accepted, in_ready=0 with C held.
//     out_ready=1 -> outputs A,B,C in order, no gaps after the first.
//  5. CNT_W=2, five 0x00000000 words transferred -> out_cls=10'h200 each, illegal_cnt=1,2,3,3,3.
//  6. flush with two records held -> out_valid=0 next cycle, nothing emitted.
//     rst low mid-stream -> out_valid=0 without a clock edge.

Source files
------------

// File: rtl/rv_decode_stage.sv
// RV32I/RV64I opcode-decode pipeline stage: one-hot class, register fields and
// sign-extended immediate, registered output with optional 1-entry skid buffer.
module rv_decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned SKID  = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [9:0]       out_cls,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [XLEN-1:0]  out_imm,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int unsigned CLS_W = 10;

  typedef struct packed {
    logic [CLS_W-1:0] cls;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [XLEN-1:0]  imm;
  } rec_t;

  rec_t             dec;
  logic [31:0]      imm32;
  rec_t             out_rec_q, out_rec_d;
  rec_t             skid_rec_q, skid_rec_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             alive_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_fire, out_fire;

  // Combinational decode of the incoming word
  always_comb begin
    dec        = '0;
    imm32      = '0;
    dec.rd     = in_inst[11:7];
    dec.rs1    = in_inst[19:15];
    dec.rs2    = in_inst[24:20];
    dec.funct3 = in_inst[14:12];
    dec.funct7 = in_inst[31:25];
    case (in_inst[6:0])
      7'b0110011: dec.cls[0] = 1'b1;
      7'b0010011: begin
        dec.cls[1] = 1'b1;
        imm32      = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      7'b0000011: begin
        dec.cls[2] = 1'b1;
        imm32      = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      7'b0100011: begin
        dec.cls[3] = 1'b1;
        imm32      = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      7'b1100011: begin
        dec.cls[4] = 1'b1;
        imm32      = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      end
      7'b1101111: begin
        dec.cls[5] = 1'b1;
        imm32      = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      end
      7'b1100111: begin
        if (in_inst[14:12] == 3'b000) begin
          dec.cls[6] = 1'b1;
          imm32      = {{20{in_inst[31]}}, in_inst[31:20]};
        end else begin
          dec.cls[9] = 1'b1;
        end
      end
      7'b0010111: begin
        dec.cls[7] = 1'b1;
        imm32      = {in_inst[31:12], 12'b0};
      end
      7'b0110111: begin
        dec.cls[8] = 1'b1;
        imm32      = {in_inst[31:12], 12'b0};
      end
      default:    dec.cls[9] = 1'b1;
    endcase
    dec.imm = XLEN'($signed(imm32));
  end

  assign out_fire = out_valid_q && out_ready;
  assign in_ready = (SKID != 0) ? in_ready_q : (alive_q && (!out_valid_q || out_ready));
  assign in_fire  = in_valid && in_ready;

  // Output/skid steering; skid only fills while the output is stalled
  always_comb begin
    out_rec_d    = out_rec_q;
    skid_rec_d   = skid_rec_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;
    if (out_fire && out_rec_q.cls[9] && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_fire || !out_valid_q) begin
      if (skid_valid_q) begin
        out_rec_d    = skid_rec_q;
        out_valid_d  = 1'b1;
        skid_valid_d = in_fire;
        if (in_fire) skid_rec_d = dec;
      end else if (in_fire) begin
        out_rec_d   = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_rec_d   = dec;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_rec_q    <= '0;
      skid_rec_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      alive_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_rec_q    <= out_rec_d;
      skid_rec_q   <= skid_rec_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      alive_q      <= 1'b1;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_cls     = out_rec_q.cls;
  assign out_rd      = out_rec_q.rd;
  assign out_rs1     = out_rec_q.rs1;
  assign out_rs2     = out_rec_q.rs2;
  assign out_funct3  = out_rec_q.funct3;
  assign out_funct7  = out_rec_q.funct7;
  assign out_imm     = out_rec_q.imm;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: decode table, skid ordering, counter saturation,
// flush and asynchronous reset.
module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_cls;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [31:0] out_imm;
  logic [1:0]  illegal_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv_decode_stage #(.XLEN(32), .SKID(1), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_cls(out_cls), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
    .illegal_cnt(illegal_cnt)
  );

  typedef struct {
    logic [31:0] inst;
    logic [9:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{32'h002081B3, 10'h001, 5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 32'h00000000};
    vecs[1]  = '{32'hFFF00093, 10'h002, 5'd1,  5'd0,  5'd31, 3'd0, 7'h7F, 32'hFFFFFFFF};
    vecs[2]  = '{32'h0020A423, 10'h008, 5'd8,  5'd1,  5'd2,  3'd2, 7'h00, 32'h00000008};
    vecs[3]  = '{32'hFE000EE3, 10'h010, 5'd29, 5'd0,  5'd0,  3'd0, 7'h7F, 32'hFFFFFFFC};
    vecs[4]  = '{32'h008000EF, 10'h020, 5'd1,  5'd0,  5'd8,  3'd0, 7'h00, 32'h00000008};
    vecs[5]  = '{32'h00008067, 10'h040, 5'd0,  5'd1,  5'd0,  3'd0, 7'h00, 32'h00000000};
    vecs[6]  = '{32'h00009067, 10'h200, 5'd0,  5'd1,  5'd0,  3'd1, 7'h00, 32'h00000000};
    vecs[7]  = '{32'h12345097, 10'h080, 5'd1,  5'd8,  5'd3,  3'd5, 7'h09, 32'h12345000};
    vecs[8]  = '{32'hFFFFF137, 10'h100, 5'd2,  5'd31, 5'd31, 3'd7, 7'h7F, 32'hFFFFF000};
    vecs[9]  = '{32'hFF812283, 10'h004, 5'd5,  5'd2,  5'd24, 3'd2, 7'h7F, 32'hFFFFFFF8};
    vecs[10] = '{32'h00000001, 10'h200, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000000};
    vecs[11] = '{32'h0000007F, 10'h200, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000000};

    // Reset state, checked while reset is asserted
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; out_ready = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_cls", 64'(out_cls), 64'd0);
    check("rst_fields", 64'({out_rd, out_rs1, out_rs2, out_funct3, out_funct7, out_imm}), 64'd0);
    check("rst_cnt", 64'(illegal_cnt), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Decode table, streaming with out_ready held high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_inst   = vecs[0].inst;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d_cls", i), 64'(out_cls), 64'(vecs[i].cls));
      check($sformatf("vec%0d_fields", i),
            64'({out_rd, out_rs1, out_rs2, out_funct3, out_funct7}),
            64'({vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].f3, vecs[i].f7}));
      check($sformatf("vec%0d_imm", i), 64'(out_imm), 64'(vecs[i].imm));
      if (i < 11) in_inst = vecs[i + 1].inst;
      else        in_valid = 1'b0;
    end
    @(negedge clk);
    check("table_drain_valid", 64'(out_valid), 64'd0);

    // Skid: A, B accepted under stall, C held; then drained in order without gaps
    do_reset();
    in_valid = 1'b1; in_inst = 32'h00000093;
    @(negedge clk);
    check("skid_A_out", 64'({out_valid, out_rd}), 64'({1'b1, 5'd1}));
    check("skid_A_in_ready", 64'(in_ready), 64'd1);
    in_inst = 32'h00000113;
    @(negedge clk);
    check("skid_full_in_ready", 64'(in_ready), 64'd0);
    check("skid_hold_A", 64'({out_valid, out_rd}), 64'({1'b1, 5'd1}));
    in_inst = 32'h00000193;
    @(negedge clk);
    check("skid_C_blocked", 64'(in_ready), 64'd0);
    check("skid_still_A", 64'({out_valid, out_rd}), 64'({1'b1, 5'd1}));
    out_ready = 1'b1;
    @(negedge clk);
    check("skid_out_B", 64'({out_valid, out_rd}), 64'({1'b1, 5'd2}));
    check("skid_reopen", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("skid_out_C", 64'({out_valid, out_rd}), 64'({1'b1, 5'd3}));
    in_valid = 1'b0;
    @(negedge clk);
    check("skid_drained", 64'(out_valid), 64'd0);

    // Saturating illegal counter with CNT_W=2
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1; in_inst = 32'h00000000;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("ill%0d_cls", i), 64'(out_cls), 64'h200);
      check($sformatf("ill%0d_cnt", i), 64'(illegal_cnt), 64'((i - 1 > 3) ? 3 : i - 1));
      if (i == 5) in_valid = 1'b0;
    end
    @(negedge clk);
    check("ill_cnt_sat", 64'(illegal_cnt), 64'd3);
    check("ill_cnt_valid", 64'(out_valid), 64'd0);

    // Flush overrides a same-cycle input transfer
    do_reset();
    in_valid = 1'b1; in_inst = 32'h00000093;
    @(negedge clk);
    in_inst = 32'h00000113; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush1_valid", 64'(out_valid), 64'd0);
    check("flush1_in_ready", 64'(in_ready), 64'd1);

    // Flush with two records held
    in_valid = 1'b1; in_inst = 32'h00000093;
    @(negedge clk);
    in_inst = 32'h00000113;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1;
    check("flush2_pre_full", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b1;
    check("flush2_valid", 64'(out_valid), 64'd0);
    check("flush2_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clk);
    check("flush2_no_emit", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00000093;
    @(negedge clk);
    in_valid = 1'b0;
    check("arst_pre_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
